// File: rtl/mem_string_reader.sv
// Memory-side string reader: fetches packed ASCII words from the data memory
// port and streams them one byte at a time over a valid/ready link.
module mem_string_reader #(
    parameter int DESCEND = 1,
    parameter int MAX_LEN = 64,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [9:0]         start_addr,
    input  logic               abort,
    output logic [9:0]         mem_addr,
    output logic               mem_read,
    output logic               mem_write,
    output logic [1:0]         mem_data_type,
    input  logic [31:0]        mem_rdata,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] byte_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAPT,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [COUNT_W-1:0] MAX_CNT   = COUNT_W'(MAX_LEN);
    localparam logic [COUNT_W-1:0] LAST_CNT  = COUNT_W'(MAX_LEN - 1);
    localparam logic [9:0]         WORD_STEP = 10'd4;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] word_buf;
    logic [1:0]  idx;
    logic [1:0]  byte_pos;
    logic [7:0]  cur_byte;
    logic        count_full;
    logic        last_byte;
    logic        handshake;

    // Byte lane inside the buffered word; descending strings read MSB first.
    assign byte_pos   = (DESCEND != 0) ? (2'd3 - idx) : idx;
    assign cur_byte   = word_buf[{byte_pos, 3'b000} +: 8];
    assign count_full = (byte_count >= MAX_CNT);
    assign last_byte  = (byte_count == LAST_CNT);

    assign tx_data       = cur_byte;
    assign tx_valid      = (state == S_EMIT) && (cur_byte != 8'h00) && !count_full;
    assign handshake     = tx_valid && tx_ready;
    assign mem_read      = (state == S_REQ);
    assign mem_write     = 1'b0;
    assign mem_data_type = 2'd0;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets its default before the case so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_REQ;
            end
            S_REQ: begin
                state_nxt = abort ? S_DONE : S_CAPT;
            end
            S_CAPT: begin
                state_nxt = abort ? S_DONE : S_EMIT;
            end
            S_EMIT: begin
                if (abort || (cur_byte == 8'h00) || count_full) begin
                    state_nxt = S_DONE;
                end else if (handshake) begin
                    // Stopping on the final allowed byte avoids fetching a word
                    // that could never be emitted.
                    if (last_byte)     state_nxt = S_DONE;
                    else if (idx == 2'd3) state_nxt = S_REQ;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: the word buffer is reset along with the control state so tx_data
    // reads a known zero immediately after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr   <= 10'd0;
            word_buf   <= 32'd0;
            idx        <= 2'd0;
            byte_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mem_addr   <= start_addr & 10'h3FC;
                        byte_count <= '0;
                        idx        <= 2'd0;
                    end
                end
                S_REQ: begin
                    // Memory drives the word on the negedge inside REQ.
                    word_buf <= mem_rdata;
                end
                S_EMIT: begin
                    if (handshake) begin
                        byte_count <= byte_count + COUNT_W'(1);
                        if (idx == 2'd3) begin
                            idx      <= 2'd0;
                            mem_addr <= (DESCEND != 0) ? (mem_addr - WORD_STEP)
                                                       : (mem_addr + WORD_STEP);
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
